// File: rtl/updown_sweep_controller.sv
// -----------------------------------------------------------------------------
// updown_sweep_controller
//
// Drives a bidirectional count pattern: lo -> hi (up leg), hi -> lo (down
// leg), repeated for a latched number of passes, then pulses done for one
// cycle and returns to IDLE. The sweep limits are captured when start is
// accepted in IDLE, so input changes mid-sweep have no effect.
//
// Optional feature (macro HOLD_STATE_EN):
//   When defined, a hold_val port exists. If lo < hold_val < hi, the value
//   hold_val is emitted on two consecutive cycles on every up leg (the extra
//   cycle is spent in the HOLD state). When undefined, the sweep is pure
//   up/down and HOLD is never entered.
//
// Parameters:
//   WIDTH     width of cnt, lo, hi, hold_val
//   PW        width of passes and pass_cnt
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous active-high reset (overrides start and pause)
//   start     sweep request, sampled only in IDLE
//   lo, hi    sweep limits, latched on accepted start
//   hold_val  repeated value (HOLD_STATE_EN only), latched on accepted start
//   passes    number of up/down passes, latched on accepted start
//   pause     freezes state, cnt and pass_cnt in UP/HOLD/DOWN
//   cnt       current count (registered)
//   dir       1 in IDLE/UP/HOLD/DONE, 0 in DOWN (registered)
//   busy      1 in UP/HOLD/DOWN (registered)
//   done      one-cycle pulse while in DONE (registered)
//   pass_cnt  passes completed in the current sweep (registered)
// -----------------------------------------------------------------------------
module updown_sweep_controller #(
  parameter int WIDTH = 3,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
`ifdef HOLD_STATE_EN
  input  logic [WIDTH-1:0] hold_val,
`endif
  input  logic [PW-1:0]    passes,
  input  logic             pause,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_HOLD,
    S_DOWN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [WIDTH-1:0] nxt_cnt;
  logic [PW-1:0]    nxt_pc;

  // Latched sweep configuration
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic [PW-1:0]    passes_r;

  // All arithmetic is WIDTH-bit unsigned; lo < hi rules out wrap in a sweep.
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] lo_inc;
  logic [PW-1:0]    pc_inc;
  logic             cfg_ok;
  logic             hold_hit;
  logic             start_acc;

  assign cnt_inc   = cnt + 1'b1;
  assign cnt_dec   = cnt - 1'b1;
  assign lo_inc    = lo_r + 1'b1;
  assign pc_inc    = pass_cnt + 1'b1;
  assign cfg_ok    = (lo < hi) && (passes != '0);
  assign start_acc = (state == S_IDLE) && start;

`ifdef HOLD_STATE_EN
  logic [WIDTH-1:0] hold_r;
  logic             hold_ok_r;   // hold_val strictly inside (lo, hi)

  assign hold_hit = hold_ok_r && (cnt_inc == hold_r);
`else
  assign hold_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-count logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pc    = pass_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_cnt   = lo;
          nxt_pc    = '0;
          // Invalid configs skip straight to the done pulse.
          nxt_state = cfg_ok ? S_UP : S_DONE;
        end
      end
      S_UP: begin
        if (!pause) begin
          if (cnt_inc == hi_r) begin
            // Reaching hi already counts as the first value of the down leg.
            nxt_cnt   = hi_r;
            nxt_state = S_DOWN;
          end else if (hold_hit) begin
            nxt_cnt   = cnt_inc;
            nxt_state = S_HOLD;
          end else begin
            nxt_cnt   = cnt_inc;
          end
        end
      end
      S_HOLD: begin
        if (!pause) nxt_state = S_UP;
      end
      S_DOWN: begin
        if (!pause) begin
          if (cnt == lo_inc) begin
            nxt_cnt   = lo_r;
            nxt_pc    = pc_inc;
            nxt_state = (pc_inc == passes_r) ? S_DONE : S_UP;
          end else begin
            nxt_cnt   = cnt_dec;
          end
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, count and output registers. Flags are decoded from the next
  // state so they line up with the registered state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pass_cnt <= '0;
      dir      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      pass_cnt <= nxt_pc;
      dir      <= (nxt_state != S_DOWN);
      busy     <= (nxt_state == S_UP) || (nxt_state == S_HOLD) ||
                  (nxt_state == S_DOWN);
      done     <= (nxt_state == S_DONE);
    end
  end

  // Configuration capture
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_r     <= '0;
      hi_r     <= '0;
      passes_r <= '0;
    end else if (start_acc) begin
      lo_r     <= lo;
      hi_r     <= hi;
      passes_r <= passes;
    end
  end

`ifdef HOLD_STATE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r    <= '0;
      hold_ok_r <= 1'b0;
    end else if (start_acc) begin
      hold_r    <= hold_val;
      hold_ok_r <= (hold_val > lo) && (hold_val < hi);
    end
  end
`endif

endmodule

// File: tb/tb_updown_sweep_controller.sv
module tb_updown_sweep_controller;

  typedef struct packed {
    logic [2:0] cnt;
    logic       dir;
    logic       busy;
    logic       done;
    logic [3:0] pc;
  } rec_t;

`ifdef HOLD_STATE_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] lo;
  logic [2:0] hi;
  logic [2:0] hold_val;
  logic [3:0] passes;
  logic       pause;
  logic [2:0] cnt;
  logic       dir;
  logic       busy;
  logic       done;
  logic [3:0] pass_cnt;

  int   total;
  int   bad;
  rec_t exp_q[$];
  rec_t sw_q[$];
  rec_t idle_rec;

  updown_sweep_controller #(.WIDTH(3), .PW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .lo       (lo),
    .hi       (hi),
`ifdef HOLD_STATE_EN
    .hold_val (hold_val),
`endif
    .passes   (passes),
    .pause    (pause),
    .cnt      (cnt),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(input int c, input bit d, input bit b,
                              input bit dn, input int p);
    rec_t r;
    r.cnt  = 3'(c);
    r.dir  = d;
    r.busy = b;
    r.done = dn;
    r.pc   = 4'(p);
    return r;
  endfunction

  // Reference: the whole sweep as a list of per-cycle outputs, ignoring pause.
  task automatic build(input int l, input int h, input int hv, input int np);
    sw_q.delete();
    if (!(l < h) || np == 0) begin
      sw_q.push_back(mk(l, 1, 0, 1, 0));
      sw_q.push_back(mk(l, 1, 0, 0, 0));
    end else begin
      for (int p = 0; p < np; p++) begin
        for (int v = l; v < h; v++) begin
          sw_q.push_back(mk(v, 1, 1, 0, p));
          if (HEN && v == hv && hv > l && hv < h)
            sw_q.push_back(mk(v, 1, 1, 0, p));
        end
        for (int v = h; v > l; v--)
          sw_q.push_back(mk(v, 0, 1, 0, p));
      end
      sw_q.push_back(mk(l, 1, 0, 1, np));
      sw_q.push_back(mk(l, 1, 0, 0, np));
    end
  endtask

  // pmode: 0 no pause, 1 random pause, 2 pause 3 cycles at first UP cnt==2.
  // rst_mid: assert reset when the sweep is in DOWN at cnt==3.
  task automatic run_sweep(input int l, input int h, input int hv,
                           input int np, input int pmode, input bit rst_mid);
    rec_t last;
    int   pause_left;
    bit   did_pause;
    bit   p;
    pause_left = 0;
    did_pause  = 1'b0;
    build(l, h, hv, np);
    @(negedge clk);
    rst      = 1'b0;
    start    = 1'b1;
    lo       = 3'(l);
    hi       = 3'(h);
    hold_val = 3'(hv);
    passes   = 4'(np);
    pause    = 1'($urandom_range(0, 1));   // ignored in IDLE
    last = sw_q.pop_front();
    exp_q.push_back(last);
    while (sw_q.size() > 0) begin
      @(negedge clk);
      // Mid-sweep input noise: must be ignored
      start    = 1'($urandom_range(0, 1));
      lo       = 3'($urandom_range(0, 7));
      hi       = 3'($urandom_range(0, 7));
      hold_val = 3'($urandom_range(0, 7));
      passes   = 4'($urandom_range(0, 15));
      if (rst_mid && last.busy && !last.dir && last.cnt == 3'd3) begin
        rst   = 1'b1;
        start = 1'b1;
        pause = 1'b1;
        idle_rec = mk(0, 1, 0, 0, 0);
        exp_q.push_back(idle_rec);
        return;
      end
      p = 1'b0;
      if (pmode == 1) p = ($urandom_range(0, 3) == 0);
      if (pmode == 2) begin
        if (!did_pause && last.busy && last.dir && last.cnt == 3'd2) begin
          did_pause  = 1'b1;
          pause_left = 3;
        end
        if (pause_left > 0) begin
          p = 1'b1;
          pause_left--;
        end
      end
      pause = p;
      if (!(last.busy && p)) last = sw_q.pop_front();
      exp_q.push_back(last);
    end
    idle_rec = last;
  endtask

  // Monitor: one output record per cycle, compared against the scoreboard.
  initial begin
    rec_t e;
    rec_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{cnt: cnt, dir: dir, busy: busy, done: done, pc: pass_cnt};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle_out t=%0t got cnt=%0d dir=%0b busy=%0b done=%0b pc=%0d want cnt=%0d dir=%0b busy=%0b done=%0b pc=%0d",
                   $time, a.cnt, a.dir, a.busy, a.done, a.pc,
                   e.cnt, e.dir, e.busy, e.done, e.pc);
        end
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b1;
    lo       = 3'd2;
    hi       = 3'd6;
    hold_val = 3'd3;
    passes   = 4'd1;
    pause    = 1'b1;
    idle_rec = mk(0, 1, 0, 0, 0);
    // Two reset cycles with start and pause high
    exp_q.push_back(idle_rec);
    @(negedge clk);
    exp_q.push_back(idle_rec);

    run_sweep(1, 4, 3, 1, 0, 1'b0);   // hold value 3 (if enabled)
    run_sweep(0, 2, 0, 2, 0, 1'b0);   // two passes
    run_sweep(1, 4, 0, 1, 2, 1'b0);   // 3-cycle pause at cnt=2
    run_sweep(5, 5, 0, 1, 0, 1'b0);   // lo==hi: invalid
    run_sweep(2, 6, 0, 0, 0, 1'b0);   // passes==0: invalid
    run_sweep(0, 5, 2, 1, 0, 1'b1);   // reset in DOWN at cnt=3
    run_sweep(6, 7, 0, 2, 0, 1'b0);   // hi==lo+1
    run_sweep(0, 7, 6, 1, 1, 1'b0);   // full range, hold near top
    for (int i = 0; i < 40; i++)
      run_sweep($urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 3), 1, 1'b0);

    // Idle tail: outputs must stay put with start low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      pause = 1'($urandom_range(0, 1));
      exp_q.push_back(idle_rec);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
